// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (also used by the ALU controller),
// execute-unit FSM states and the op-code width.
package alu_pkg;

    localparam int ALU_OP_WIDTH = 4;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SLL = 4'b0100,
        OP_SRL = 4'b0101,
        OP_SUB = 4'b0110,
        OP_SRA = 4'b0111,
        OP_BEQ = 4'b1000,
        OP_MUL = 4'b1010,
        OP_SLT = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MUL,
        ST_DONE
    } alu_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, DATA_WIDTH cycles,
// returns the low DATA_WIDTH bits. Only instantiated when ALU_MUL_EN is defined.
module alu_seq_mul #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product
);
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [CW-1:0]         r_count;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] w_addend;

    // product is the accumulator after the current step, so it is final while done is high
    assign w_addend = r_mplier[0] ? r_mcand : '0;
    assign product  = r_acc + w_addend;
    assign done     = r_busy && (r_count == CW'(1));
    assign busy     = r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else if (flush) begin
            r_acc   <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
        end else if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_count  <= CW'(DATA_WIDTH);
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= product;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - 1'b1;
            if (r_count == CW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes: single-cycle logic/arith ops,
// one-bit-per-cycle shifts and an optional iterative multiplier (macro ALU_MUL_EN).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ALU_OP_WIDTH-1:0] in_op,
    input  logic [DATA_WIDTH-1:0]   in_a,
    input  logic [DATA_WIDTH-1:0]   in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_result,
    output logic                    out_zero,
    output logic                    out_illegal
);
    localparam int SW = $clog2(DATA_WIDTH);

    alu_state_e              r_state;
    alu_state_e              w_next_state;
    alu_state_e              w_accept_state;
    logic [DATA_WIDTH-1:0]   r_work;
    logic [DATA_WIDTH-1:0]   r_result;
    logic [SW-1:0]           r_count;
    logic [ALU_OP_WIDTH-1:0] r_op;
    logic                    r_illegal;

    logic                    w_accept;
    logic                    w_is_shift;
    logic                    w_is_mul;
    logic                    w_illegal;
    logic [SW-1:0]           w_amount;
    logic [DATA_WIDTH-1:0]   w_single_result;
    logic [DATA_WIDTH-1:0]   w_shift_step;
    logic                    w_mul_busy;
    logic                    w_mul_done;
    logic [DATA_WIDTH-1:0]   w_product;

    assign in_ready    = !flush && ((r_state == ST_IDLE) || (r_state == ST_DONE && out_ready));
    assign w_accept    = in_valid && in_ready;
    assign w_amount    = in_b[SW-1:0];
    assign out_valid   = (r_state == ST_DONE);
    assign out_result  = r_result;
    assign out_zero    = (r_result == '0);
    assign out_illegal = r_illegal;

    always_comb begin
        w_single_result = '0;
        w_is_shift      = 1'b0;
        w_is_mul        = 1'b0;
        w_illegal       = 1'b0;
        case (in_op)
            OP_AND:                 w_single_result = in_a & in_b;
            OP_OR:                  w_single_result = in_a | in_b;
            OP_ADD:                 w_single_result = in_a + in_b;
            OP_SUB, OP_BEQ:         w_single_result = in_a - in_b;
            OP_SLT:                 w_single_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLL, OP_SRL, OP_SRA: w_is_shift      = 1'b1;
`ifdef ALU_MUL_EN
            OP_MUL:                 w_is_mul        = 1'b1;
`endif
            default:                w_illegal       = 1'b1;
        endcase
    end

    always_comb begin
        w_shift_step = r_work >> 1;
        case (r_op)
            OP_SLL:  w_shift_step = r_work << 1;
            OP_SRA:  w_shift_step = {r_work[DATA_WIDTH-1], r_work[DATA_WIDTH-1:1]};
            default: w_shift_step = r_work >> 1;
        endcase
    end

`ifdef ALU_MUL_EN
    alu_seq_mul #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .start   (w_accept && w_is_mul),
        .a       (in_a),
        .b       (in_b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_product)
    );
`else
    assign w_mul_busy = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_product  = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A zero shift amount completes like a single-cycle op
    always_comb begin
        if (w_is_mul) begin
            w_accept_state = ST_MUL;
        end else if (w_is_shift && (w_amount != '0)) begin
            w_accept_state = ST_SHIFT;
        end else begin
            w_accept_state = ST_DONE;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = w_accept_state;
            ST_SHIFT: if (r_count == SW'(1)) w_next_state = ST_DONE;
            ST_MUL:   if (w_mul_done || !w_mul_busy) w_next_state = ST_DONE;
            ST_DONE: begin
                if (w_accept) begin
                    w_next_state = w_accept_state;
                end else if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default:  w_next_state = ST_IDLE;
        endcase
        if (flush) begin
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_work    <= '0;
            r_result  <= '0;
            r_count   <= '0;
            r_op      <= '0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_work  <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_op      <= in_op;
            r_work    <= in_a;
            r_count   <= w_amount;
            r_illegal <= w_illegal;
            if (w_is_shift && (w_amount == '0)) begin
                r_result <= in_a;
            end else if (!w_is_shift && !w_is_mul) begin
                r_result <= w_single_result;
            end
        end else if (r_state == ST_SHIFT) begin
            r_work  <= w_shift_step;
            r_count <= r_count - 1'b1;
            if (r_count == SW'(1)) begin
                r_result <= w_shift_step;
            end
        end else if (r_state == ST_MUL && w_mul_done) begin
            r_result <= w_product;
        end
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execute-stage ALU that consumes the 4-bit `Operation` code produced by the ALU controller, together with two operands, and returns a registered result and zero flag. It uses a valid/ready handshake on both sides. Logic ops, add/sub, compare and BEQ finish in one cycle. Shifts run iteratively at one bit per cycle, and an optional iterative multiplier can be compiled in. The block sits between the ID/EX pipeline register and the EX/MEM register, and stalls the pipeline through `in_ready`.

## Interface
- `DATA_WIDTH`, 32, operand/result width; power of two, at least 8
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `flush`  in  1  synchronous kill of any in-flight op (branch mispredict)
- `in_valid`  in  1  operation/operands valid
- `in_ready`  out  1  unit can accept this cycle
- `in_op`  in  4  Operation code (alu_op_e)
- `in_a`, `in_b`  in  DATA_WIDTH  operands; shift amount is `in_b[$clog2(DATA_WIDTH)-1:0]`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_result`  out  DATA_WIDTH  result
- `out_zero`  out  1  `out_result == 0`
- `out_illegal`  out  1  the op code was unassigned

## Operation
- Codes: AND 0000; OR 0001; ADD 0010; SLL 0100; SRL 0101; SUB 0110; SRA 0111; BEQ 1000 (result A−B); SLT 1100 (signed A<B → 1, else 0); MUL 1010 (low DATA_WIDTH bits of A×B, only when compiled in). All other codes are illegal: result 0, `out_illegal`=1, single-cycle timing.
- Arithmetic is modulo 2^DATA_WIDTH with no overflow flag. SRA replicates `in_a` MSB.
- States:
  - IDLE: `in_ready`=1.
  - SHIFT: iterate shifts.
  - MUL: iterate multiply.
  - DONE: `out_valid`=1.
- Accept means `in_valid && in_ready && !flush`. On accept, operands and op are captured into internal registers, and later `in_*` changes are ignored.
- Single-cycle op: goes to DONE and `out_result` is loaded on the accept edge.
- Shift op: the counter is loaded with the shift amount.
  - Amount 0: go straight to DONE, with result = A.
  - Otherwise: go to SHIFT and shift one bit per cycle, decrementing the counter. When the counter reaches 1, go to DONE.
- MUL: shift-add, one multiplier bit per cycle, DATA_WIDTH cycles in MUL, then DONE.
- DONE holds `out_result`, `out_zero` and `out_illegal` stable until `out_ready`.
  - With `out_ready`=1 and no new accept: go to IDLE.
  - With a new accept in the same cycle: follow the new op's transition directly (back-to-back).
- `in_ready` = (state==IDLE) || (state==DONE && out_ready). `in_ready` is forced 0 while `flush`=1.
- `flush` (synchronous, highest priority after reset): go to IDLE, clear `out_valid`, discard the counter and partial result. `out_result` is not required to clear.
- `reset` mid-operation: asynchronous return to IDLE and all registers cleared.

## Timing
- Reset values: `out_valid`=0, `out_result`=0, `out_zero`=1, `out_illegal`=0, state IDLE, so `in_ready`=1 while and after reset.
- Latency from accept edge to `out_valid` high:
  - single-cycle ops and shift by 0: 1 cycle
  - shift by n: n+1 cycles
  - MUL: DATA_WIDTH+1 cycles
- Throughput: one single-cycle op per clock when `out_ready` is held high.
- `out_valid` must not drop without `out_ready` or `flush`.
- All outputs are registered or decoded from state only; there are no combinational paths from `in_*` to `out_*`.

## Configuration
- `ALU_MUL_EN` defined: the MUL code 1010 is legal and the MUL state and `alu_seq_mul` are instantiated.
- `ALU_MUL_EN` undefined: 1010 is treated as illegal (result 0, `out_illegal`=1, 1-cycle), and there is no multiplier logic in the netlist.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` enum of the 4-bit codes above, shared with the ALU controller
  - `alu_state_e` (IDLE, SHIFT, MUL, DONE)
  - the `ALU_OP_WIDTH`=4 constant
- Sub-module `alu_seq_mul`: parameter DATA_WIDTH; ports start/a/b, busy/done/product. It is instantiated only under `ALU_MUL_EN`.
- The shifter, logic and add/sub live in `alu_exec_unit`.

## Test plan
- Reset: assert `reset` mid-SHIFT (SLL, amount 20, at cycle 5) → the next edge shows `out_valid`=0, `in_ready`=1, `out_zero`=1.
- Back-to-back ADD 5+7 then SUB 3−3, with `out_ready`=1 → results 12 then 0 on consecutive cycles; `out_zero`=0 then 1.
- SRA 0x8000_0000 by 4 → `out_valid` exactly 5 cycles after accept with 0xF800_0000; `in_ready`=0 during SHIFT. SLL by 0 → 1 cycle, result = A.
- Backpressure on SLT −1<1: hold `out_ready`=0 for 3 cycles → `out_result`=1 held stable, `in_ready`=0; release → the next op is accepted on the same edge.
- `flush` in the 10th MUL cycle of 0xFFFF×0x10001 → IDLE next cycle with no `out_valid`. Rerun unflushed → 0xFFFF_FFFF after 33 cycles (`ALU_MUL_EN`). Without the macro → 1 cycle, result 0, `out_illegal`=1.
- Illegal code 1111 → 1 cycle, result 0, `out_illegal`=1, `out_zero`=1.
